imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_word_packer.sv | 33 +++
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: state encoding and
// the running checksum helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_WORD   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_e;

    // Frame checksum is a plain XOR over every byte preceding the check byte.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles four consecutive bytes into a little-endian 32-bit word; the
// first byte lands in bits [7:0]. full_o flags the cycle the 4th byte arrives.
module imem_loader_byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    // Shift new bytes in from the top so byte0 ends up in the low lane.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q  <= 2'd0;
            word_q <= 32'h0000_0000;
        end else if (in_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= {in_data_i, word_q[31:8]};
        end else begin
            cnt_q  <= cnt_q;
            word_q <= word_q;
        end
    end

    assign word_o = word_q;
    assign full_o = in_valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a length/payload/checksum byte
// frame, writes words to IMEM and releases the CPU reset once verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DATA_LEN   = 32,
    parameter int                  IMEM_DEPTH = 256,
    parameter logic [ADDR_LEN-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                imem_we,
    output logic [ADDR_LEN-1:0] imem_addr,
    output logic [DATA_LEN-1:0] imem_wdata,
    output logic                cpu_rst,
    output logic                done,
    output logic                error,
    output logic [15:0]         words_written
);

    localparam logic [15:0]         DEPTH_W   = 16'(IMEM_DEPTH);
    localparam logic [ADDR_LEN-1:0] ADDR_STEP = ADDR_LEN'(4);

    loader_state_e       state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          acc_q, acc_d;
    logic [15:0]         ww_q, ww_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                in_ready_q, we_q, cpu_rst_q, done_q, error_q;

    logic        accept_s;
    logic        clear_s;
    logic        pack_valid_s;
    logic        pack_full_s;
    logic [31:0] pack_word_s;
    logic [15:0] len_full_s;

    assign accept_s     = in_valid && in_ready_q;
    assign clear_s      = start && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    assign pack_valid_s = accept_s && (state_q == ST_WORD);
    assign len_full_s   = {in_data, len_q[7:0]};

    imem_loader_byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clear_s),
        .in_valid_i (pack_valid_s),
        .in_data_i  (in_data),
        .word_o     (pack_word_s),
        .full_o     (pack_full_s)
    );

    // Next-state, checksum, length and address bookkeeping.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        ww_d    = ww_q;
        addr_d  = addr_q;
        case (state_q)
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_d[7:0] = in_data;
                    acc_d      = xor_fold(acc_q, in_data);
                    state_d    = ST_LEN_HI;
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_d = len_full_s;
                    acc_d = xor_fold(acc_q, in_data);
                    if (len_full_s > DEPTH_W) begin
                        state_d = ST_ERROR;
                    end else if (len_full_s == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_WORD;
                    end
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_WORD: begin
                if (accept_s) begin
                    acc_d = xor_fold(acc_q, in_data);
                    if (pack_full_s) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_WORD;
                    end
                end else begin
                    state_d = ST_WORD;
                end
            end
            ST_WRITE: begin
                ww_d   = ww_q + 16'd1;
                addr_d = addr_q + ADDR_STEP;
                if ((ww_q + 16'd1) == len_q) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_WORD;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (in_data == acc_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (clear_s) begin
                    state_d = ST_LEN_LO;
                    len_d   = 16'd0;
                    acc_d   = 8'h00;
                    ww_d    = 16'd0;
                    addr_d  = BASE_ADDR;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_LEN_LO;
            end
        endcase
    end

    // State register plus outputs registered from the next state, so each
    // flag lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LEN_LO;
            len_q      <= 16'd0;
            acc_q      <= 8'h00;
            ww_q       <= 16'd0;
            addr_q     <= BASE_ADDR;
            in_ready_q <= 1'b1;
            we_q       <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            ww_q       <= ww_d;
            addr_q     <= addr_d;
            in_ready_q <= !((state_d == ST_WRITE) || (state_d == ST_DONE));
            we_q       <= (state_d == ST_WRITE);
            cpu_rst_q  <= (state_d != ST_DONE);
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERROR);
        end
    end

    assign in_ready      = in_ready_q;
    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = DATA_LEN'(pack_word_s);
    assign cpu_rst       = cpu_rst_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected IMEM writes are queued by the
// stimulus thread and popped/compared by an independent write monitor.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  frame_q[$];

    imem_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_rst       (cpu_rst),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we) begin
            logic [63:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, none expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: got in_ready %b, expected 0", in_ready);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        int guard;
        if (gaps) begin
            guard = 0;
            while ($urandom_range(0, 1) == 1 && guard < 8) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                guard++;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        ok       = 1'b0;
        while (!ok && guard < 50) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: byte %h not accepted, expected acceptance within 50 cycles", b);
        end
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame_q[i]) send_byte(frame_q[i], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load_frame_a(input logic [7:0] chk_byte);
        frame_q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                    8'hAA, 8'hBB, 8'hCC, 8'hDD, chk_byte};
    endtask

    task automatic push_frame_a_writes();
        exp_q.push_back({32'h0000_0000, 32'h0403_0201});
        exp_q.push_back({32'h0000_0004, 32'hDDCC_BBAA});
    endtask

    task automatic push_frame_b_writes();
        exp_q.push_back({32'h0000_0000, 32'h4433_2211});
        exp_q.push_back({32'h0000_0004, 32'h8877_6655});
        exp_q.push_back({32'h0000_0008, 32'hCCBB_AA99});
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0000_0000);
        chk("rst_imem_wdata", imem_wdata, 32'h0000_0000);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_words", {16'd0, words_written}, 32'd0);

        // Two-word frame, checksum 0x06.
        load_frame_a(8'h06);
        push_frame_a_writes();
        send_frame(1'b0);
        chk("a_done", {31'd0, done}, 32'd1);
        chk("a_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("a_words", {16'd0, words_written}, 32'd2);
        chk("a_error", {31'd0, error}, 32'd0);
        chk("a_in_ready", {31'd0, in_ready}, 32'd0);

        // Bad checksum, stray bytes while in error, then recovery.
        pulse_start();
        chk("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_words", {16'd0, words_written}, 32'd0);
        load_frame_a(8'hF9);
        push_frame_a_writes();
        send_frame(1'b0);
        chk("bad_error", {31'd0, error}, 32'd1);
        chk("bad_done", {31'd0, done}, 32'd0);
        chk("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("bad_in_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        chk("bad_still_error", {31'd0, error}, 32'd1);
        pulse_start();
        load_frame_a(8'h06);
        push_frame_a_writes();
        send_frame(1'b0);
        chk("retry_done", {31'd0, done}, 32'd1);
        chk("retry_error", {31'd0, error}, 32'd0);

        // Empty image.
        pulse_start();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_words", {16'd0, words_written}, 32'd0);
        chk("empty_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        // Length one beyond capacity.
        pulse_start();
        frame_q = '{8'h01, 8'h01};
        send_frame(1'b0);
        chk("ovf_error", {31'd0, error}, 32'd1);
        chk("ovf_words", {16'd0, words_written}, 32'd0);
        chk("ovf_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Three-word frame, checksum 0xCF, without and with input gaps.
        pulse_start();
        frame_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                    8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
        push_frame_b_writes();
        send_frame(1'b0);
        chk("b_done", {31'd0, done}, 32'd1);
        chk("b_words", {16'd0, words_written}, 32'd3);
        pulse_start();
        push_frame_b_writes();
        send_frame(1'b1);
        chk("b_gap_done", {31'd0, done}, 32'd1);
        chk("b_gap_words", {16'd0, words_written}, 32'd3);

        // Reset in the middle of the second word.
        pulse_start();
        exp_q.push_back({32'h0000_0000, 32'h0403_0201});
        frame_q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
        send_frame(1'b0);
        chk("mid_words_before", {16'd0, words_written}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("mid_words", {16'd0, words_written}, 32'd0);
        chk("mid_addr", imem_addr, 32'h0000_0000);
        load_frame_a(8'h06);
        push_frame_a_writes();
        send_frame(1'b0);
        chk("mid_reload_done", {31'd0, done}, 32'd1);

        // start during WORD is ignored.
        pulse_start();
        push_frame_a_writes();
        frame_q = '{8'h02, 8'h00, 8'h01, 8'h02};
        send_frame(1'b0);
        pulse_start();
        frame_q = '{8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h06};
        send_frame(1'b0);
        chk("ign_start_done", {31'd0, done}, 32'd1);
        chk("ign_start_words", {16'd0, words_written}, 32'd2);

        // rst and start together: reset values, then a fresh empty frame.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rs_done", {31'd0, done}, 32'd0);
        chk("rs_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rs_words", {16'd0, words_written}, 32'd0);
        chk("rs_addr", imem_addr, 32'h0000_0000);
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        chk("rs_empty_done", {31'd0, done}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_writes", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
